e_md_unit: RTL and testbench
============================

Name: e_md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs operand and the forwarded rt operand (output of the E-stage ALU operand-2 forwarding mux).
- Owns the HI/LO architectural registers and reports a stall request to the hazard unit while busy.
- Serves mult/multu/div/divu/mthi/mtlo; mfhi/mflo read the hi/lo outputs.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal 1..15).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- E_src_a  input  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source).
- E_src_b  input  32  forwarded rt value from the operand-2 forwarding mux (divisor / multiplier).
- md_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- start  input  1  qualifies md_op this cycle; the hazard unit deasserts it on E-stage bubbles.
- busy  output  1  registered; high while an operation is in flight.
- md_stall  output  1  combinational: busy | (start & md_op in 1..4); hazard unit stalls any md-class instruction in D while high.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous active-high: hi=0, lo=0, busy=0, cycle counter=0, pending results=0.
- Reset mid-operation aborts the operation. HI/LO stay 0; nothing is committed after reset releases.
- States: IDLE and RUN. busy = (state == RUN).
- Launch, IDLE, edge T0 with start=1 and md_op in 1..4:
  - compute the full result from E_src_a/E_src_b sampled at T0 into pending_hi/pending_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, commit pending to hi/lo and go to IDLE.
- busy is therefore high for exactly N cycles after T0. The new hi/lo are visible on the first cycle busy is low.
- mthi/mtlo in IDLE with start=1: at the next edge hi (or lo) = E_src_a, with 1-cycle latency. The other register is unchanged; busy stays 0.
- Any start while in RUN (any md_op) is ignored. No effect on state, pending or hi/lo; md_stall already high.
- md_op 0 or 7, or start=0: no action.
- mult: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
- multu: same as mult, unsigned.
- div: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (div or divu): full DIV_CYCLES busy, then hi/lo keep their prior values (no commit).
- Operands are captured at launch. Later changes on E_src_a/E_src_b, such as forwarding changes during the stall, have no effect.
- hi/lo hold their old values throughout RUN; reading them mid-op returns pre-op values. The hazard unit prevents this via md_stall.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> hi=0, lo=0, busy=0 immediately, without waiting for a clock edge.
- mult 0xFFFFFFFF x 0x00000002 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 / 2 -> lo=3, hi=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Division by zero: preload hi=0x11, lo=0x22 via mthi/mtlo, then divu x/0 -> busy 10 cycles, hi=0x11, lo=0x22 afterwards.
- Collisions during multu in RUN:
  - start=1 with mtlo 0xDEAD on cycle 2, then mult on cycle 3 -> both ignored; final result is that of the original multu.
  - md_stall high throughout; change E_src_a/E_src_b mid-op -> result unchanged.
- Abort: launch div, assert reset on cycle 4 -> busy=0, hi=lo=0 with no later commit. After release, mthi 0x1234 -> hi=0x1234 one edge later, lo stays 0.

Source files
------------

// File: rtl/e_md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes the full result at launch
// and commits it after a fixed busy window, raising md_stall while in flight.
module e_md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_src_a,
  input  logic [31:0] E_src_b,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_t;

  state_t      state, state_nx;
  md_op_t      op;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] pend_hi, pend_hi_nx;
  logic [31:0] pend_lo, pend_lo_nx;
  logic        pend_ok, pend_ok_nx;
  logic [31:0] hi_q, hi_nx;
  logic [31:0] lo_q, lo_nx;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, b_div;
  logic [31:0] uq, ur, sq, sr;
  logic [31:0] udq, udr;
  logic        b_zero;

  assign op = md_op_t'(md_op);

  assign prod_s = {{32{E_src_a[31]}}, E_src_a} * {{32{E_src_b[31]}}, E_src_b};
  assign prod_u = {32'd0, E_src_a} * {32'd0, E_src_b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on simulator behaviour for the overflow case.
  assign a_mag  = E_src_a[31] ? (32'd0 - E_src_a) : E_src_a;
  assign b_mag  = E_src_b[31] ? (32'd0 - E_src_b) : E_src_b;
  assign b_zero = (E_src_b == '0);
  assign b_safe = b_zero ? 32'd1 : b_mag;
  assign b_div  = b_zero ? 32'd1 : E_src_b;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;
  assign sq     = (E_src_a[31] ^ E_src_b[31]) ? (32'd0 - uq) : uq;
  assign sr     = E_src_a[31] ? (32'd0 - ur) : ur;
  assign udq    = E_src_a / b_div;
  assign udr    = E_src_a % b_div;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    pend_ok_nx = pend_ok;
    hi_nx      = hi_q;
    lo_nx      = lo_q;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              pend_hi_nx = prod_s[63:32];
              pend_lo_nx = prod_s[31:0];
              pend_ok_nx = 1'b1;
              cnt_nx     = 4'(MULT_CYCLES);
              state_nx   = RUN;
            end
            OP_MULTU: begin
              pend_hi_nx = prod_u[63:32];
              pend_lo_nx = prod_u[31:0];
              pend_ok_nx = 1'b1;
              cnt_nx     = 4'(MULT_CYCLES);
              state_nx   = RUN;
            end
            OP_DIV: begin
              pend_hi_nx = sr;
              pend_lo_nx = sq;
              pend_ok_nx = !b_zero;
              cnt_nx     = 4'(DIV_CYCLES);
              state_nx   = RUN;
            end
            OP_DIVU: begin
              pend_hi_nx = udr;
              pend_lo_nx = udq;
              pend_ok_nx = !b_zero;
              cnt_nx     = 4'(DIV_CYCLES);
              state_nx   = RUN;
            end
            OP_MTHI: hi_nx = E_src_a;
            OP_MTLO: lo_nx = E_src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = IDLE;
          if (pend_ok) begin
            hi_nx = pend_hi;
            lo_nx = pend_lo;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt     <= cnt_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      pend_ok <= pend_ok_nx;
      hi_q    <= hi_nx;
      lo_q    <= lo_nx;
    end
  end

  assign busy     = (state == RUN);
  assign md_stall = busy | (start & (md_op >= 3'd1) & (md_op <= 3'd4));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_e_md_unit.sv
// Directed self-checking bench for e_md_unit with hand-computed HI/LO results.
module tb_e_md_unit;

  logic        clk;
  logic        reset;
  logic [31:0] E_src_a;
  logic [31:0] E_src_b;
  logic [2:0]  md_op;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests;
  int n_fail;
  int cyc;

  e_md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .E_src_a (E_src_a),
    .E_src_b (E_src_b),
    .md_op   (md_op),
    .start   (start),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one started op for a single edge; returns at the negedge after it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op   = op;
    E_src_a = a;
    E_src_b = b;
    start   = 1'b1;
    #1;
    check("stall_at_launch", {31'd0, md_stall}, {31'd0, (op >= 3'd1) && (op <= 3'd4)});
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    md_op   = 3'd0;
    E_src_a = '0;
    E_src_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Async reset with non-zero HI/LO, checked before any clock edge.
    issue(3'd5, 32'h0000AAAA, 32'h0);
    issue(3'd6, 32'h00005555, 32'h0);
    check("pre_reset_hi", hi, 32'h0000AAAA);
    #2 reset = 1'b1;
    #1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
    check("mult_hold_lo", lo, 32'h0);
    wait_done(cyc);
    check("mult_cycles", cyc, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
    wait_done(cyc);
    check("multu_cycles", cyc, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd3, 32'hFFFFFFF9, 32'h00000002);
    wait_done(cyc);
    check("div_cycles", cyc, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd4, 32'd7, 32'd2);
    wait_done(cyc);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'h0);

    // Divide by zero leaves preloaded HI/LO untouched.
    issue(3'd5, 32'h11, 32'h0);
    check("mthi_hi", hi, 32'h11);
    check("mthi_lo_kept", lo, 32'h80000000);
    issue(3'd6, 32'h22, 32'h0);
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi_kept", hi, 32'h11);
    issue(3'd4, 32'd5, 32'd0);
    wait_done(cyc);
    check("div0_cycles", cyc, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Collisions and operand changes while multu is running.
    issue(3'd2, 32'h12345678, 32'h00000100);
    check("coll_busy_c1", {31'd0, busy}, 32'd1);
    start   = 1'b1;
    md_op   = 3'd6;
    E_src_a = 32'h0000DEAD;
    @(negedge clk);
    check("coll_stall_c2", {31'd0, md_stall}, 32'd1);
    check("coll_lo_hold", lo, 32'h22);
    md_op   = 3'd1;
    E_src_a = 32'd5;
    E_src_b = 32'd7;
    @(negedge clk);
    check("coll_stall_c3", {31'd0, md_stall}, 32'd1);
    start   = 1'b0;
    md_op   = 3'd0;
    E_src_a = 32'hFFFFFFFF;
    E_src_b = 32'hFFFFFFFF;
    wait_done(cyc);
    check("coll_remaining", cyc, 32'd3);
    check("coll_hi", hi, 32'h00000012);
    check("coll_lo", lo, 32'h34567800);

    // Abort a divide with reset on its fourth busy cycle.
    issue(3'd3, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_busy_late", {31'd0, busy}, 32'd0);
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);
    issue(3'd5, 32'h1234, 32'h0);
    check("post_abort_hi", hi, 32'h1234);
    check("post_abort_lo", lo, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
